// File: rtl/byte_word_packer.sv
// byte_word_packer
// Packs a stream of byte writes into 32-bit little-endian words and queues
// them in a show-ahead FIFO. The head word is offered on a valid/ready
// interface.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   iv_data        byte from the cdc stage
//   i_data_wr      byte strobe, iv_data sampled on every edge it is high
//   i_flush        emit the current partial word (after any write this edge)
//   i_word_ready   downstream accepts the head word
//   ov_word        head word, byte 0 in [7:0]
//   ov_word_bytes  valid byte count of the head word (1..4)
//   o_word_valid   FIFO not empty
//   o_overflow     sticky: a word was dropped because the FIFO was full
//   ov_err_cnt     byte sequence error count (saturating)
//
// Optional feature macro: BYTE_WORD_PACKER_SEQCHK_EN
//   defined   -> each byte is checked against previous byte + 1
//   undefined -> ov_err_cnt is tied to 0
module byte_word_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  iv_data,
  input  logic        i_data_wr,
  input  logic        i_flush,
  input  logic        i_word_ready,
  output logic [31:0] ov_word,
  output logic [2:0]  ov_word_bytes,
  output logic        o_word_valid,
  output logic        o_overflow,
  output logic [15:0] ov_err_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // ---------------- assembly ----------------
  logic [1:0]  cnt;
  logic [23:0] hold;
  logic [2:0]  eff_cnt;
  logic        full_push;
  logic        flush_push;
  logic        push;
  logic [31:0] push_word;
  logic [2:0]  push_bytes;

  assign eff_cnt    = {1'b0, cnt} + {2'b00, i_data_wr};
  assign full_push  = i_data_wr && (cnt == 2'd3);
  assign flush_push = i_flush && (eff_cnt != 3'd0) && (eff_cnt != 3'd4);
  assign push       = full_push || flush_push;
  assign push_bytes = eff_cnt;

  // hold is cleared whenever a word leaves, so lanes above cnt are always
  // zero and a partial word needs no masking.
  always_comb begin
    push_word = {8'h00, hold};
    if (i_data_wr) begin
      case (cnt)
        2'd0:    push_word[7:0]   = iv_data;
        2'd1:    push_word[15:8]  = iv_data;
        2'd2:    push_word[23:16] = iv_data;
        default: push_word[31:24] = iv_data;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= 2'd0;
      hold <= 24'h0;
    end else if (push) begin
      cnt  <= 2'd0;
      hold <= 24'h0;
    end else if (i_data_wr) begin
      cnt  <= cnt + 2'd1;
      hold <= push_word[23:0];
    end
  end

  // ---------------- FIFO ----------------
  logic [31:0] mem_word  [FIFO_DEPTH];
  logic [2:0]  mem_bytes [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] next_wr;
  logic [AW:0] next_rd;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && i_word_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign next_wr = wr_ptr + (AW+1)'(push_ok);
  assign next_rd = rd_ptr + (AW+1)'(pop);

  assign o_word_valid = !empty;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_word[wr_ptr[AW-1:0]]  <= push_word;
      mem_bytes[wr_ptr[AW-1:0]] <= push_bytes;
    end
  end

  // Head word is registered so it keeps its last value once the FIFO drains.
  // When the slot about to become head is being written on this edge, the
  // incoming word is taken directly since memory is not yet updated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ov_word       <= 32'h0;
      ov_word_bytes <= 3'd0;
      o_overflow    <= 1'b0;
    end else begin
      wr_ptr <= next_wr;
      rd_ptr <= next_rd;
      if (drop) o_overflow <= 1'b1;
      if (next_wr != next_rd) begin
        if (push_ok && (wr_ptr == next_rd)) begin
          ov_word       <= push_word;
          ov_word_bytes <= push_bytes;
        end else begin
          ov_word       <= mem_word[next_rd[AW-1:0]];
          ov_word_bytes <= mem_bytes[next_rd[AW-1:0]];
        end
      end
    end
  end

  // ---------------- sequence check ----------------
`ifdef BYTE_WORD_PACKER_SEQCHK_EN
  logic [7:0]  last_byte;
  logic        have_ref;
  logic [15:0] err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_byte <= 8'h00;
      have_ref  <= 1'b0;
      err_cnt   <= 16'h0;
    end else if (i_data_wr) begin
      last_byte <= iv_data;
      have_ref  <= 1'b1;
      if (have_ref && (iv_data != last_byte + 8'd1) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

  assign ov_err_cnt = err_cnt;
`else
  assign ov_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        data_wr;
  logic        flush;
  logic        word_ready;
  logic [31:0] word;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        overflow;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  byte_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .iv_data      (data),
    .i_data_wr    (data_wr),
    .i_flush      (flush),
    .i_word_ready (word_ready),
    .ov_word      (word),
    .ov_word_bytes(word_bytes),
    .o_word_valid (word_valid),
    .o_overflow   (overflow),
    .ov_err_cnt   (err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: words as queue entries, partial word as a byte list.
  typedef struct {
    logic [31:0] w;
    logic [2:0]  b;
  } ent_t;
  ent_t      mq[$];
  bit [7:0]  pb[$];
  bit        m_ovf;
  int        m_err;
  bit        m_have;
  bit [7:0]  m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'b0, word_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("word", word, mq[0].w);
      chk("bytes", {29'b0, word_bytes}, {29'b0, mq[0].b});
    end
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("err_cnt", {16'b0, err_cnt}, m_err);
  endtask

  task automatic model_edge(input bit wr, input bit [7:0] d, input bit fl, input bit rdy);
    ent_t e;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (wr) begin
`ifdef BYTE_WORD_PACKER_SEQCHK_EN
      if (m_have && d != 8'(m_last + 8'd1) && m_err < 65535) m_err++;
`endif
      m_have = 1;
      m_last = d;
      pb.push_back(d);
    end
    if (pb.size() == 4 || (fl && pb.size() > 0)) begin
      e.w = 0;
      for (int i = 0; i < pb.size(); i++) e.w = e.w + (32'(pb[i]) << (8 * i));
      e.b = 3'(pb.size());
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
      pb.delete();
    end
  endtask

  task automatic step(input bit wr, input bit [7:0] d, input bit fl, input bit rdy);
    data_wr    = wr;
    data       = d;
    flush      = fl;
    word_ready = rdy;
    @(posedge clk);
    model_edge(wr, d, fl, rdy);
    vectors++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    data_wr = 0; flush = 0; word_ready = 0; data = 0;
    rst_n = 0;
    #2;
    chk("rst_valid", {31'b0, word_valid}, 0);
    chk("rst_word", word, 0);
    chk("rst_bytes", {29'b0, word_bytes}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_err", {16'b0, err_cnt}, 0);
    mq.delete(); pb.delete();
    m_ovf = 0; m_err = 0; m_have = 0; m_last = 0;
    rst_n = 1;
  endtask

  initial begin
    bit [7:0] d;
    rst_n = 0; data = 0; data_wr = 0; flush = 0; word_ready = 0;
    m_ovf = 0; m_err = 0; m_have = 0; m_last = 0;
    #7;
    do_reset();

    // 1: back-to-back bytes, ready high
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 1);
      if (i == 4) begin
        chk("t1_first_valid", {31'b0, word_valid}, 1);
        chk("t1_first_word", word, 32'h04030201);
      end
    end
    step(0, 0, 0, 1);

    // 2: partial word flush, then redundant flush
    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t2_pending", {31'b0, word_valid}, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // 3: overflow with ready low, then drain
    for (int i = 1; i <= 20; i++) step(1, 8'(i), 0, 0);
    chk("t3_ovf", {31'b0, overflow}, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // 4: flush together with the third byte
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hCC, 1, 0);
    chk("t4_word", word, 32'h00CCBBAA);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1);
    step(0, 0, 0, 1);

    // 5: full FIFO, pop and push on the same edge
    do_reset();
    for (int i = 1; i <= 19; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd20, 0, 1);
    chk("t5_no_ovf", {31'b0, overflow}, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0);
    do_reset();
    for (int i = 8'h11; i <= 8'h14; i++) step(1, 8'(i), 0, 0);
    chk("t5_word", word, 32'h14131211);
    step(0, 0, 0, 1);

    // 6: sequence check
    do_reset();
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h05, 0, 0);
    step(1, 8'h06, 1, 0);
`ifdef BYTE_WORD_PACKER_SEQCHK_EN
    chk("t6_err", {16'b0, err_cnt}, 1);
`else
    chk("t6_err", {16'b0, err_cnt}, 0);
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // random traffic
    do_reset();
    d = 8'($urandom);
    for (int i = 0; i < 500; i++) begin
      bit wr, fl, rdy;
      if (i == 250) do_reset();
      wr  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = (i % 100 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(d + 8'd1);
      step(wr, d, fl, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Downstream consumer of the cdc stage's `ov_data`/`o_data_wr` byte stream.
- Packs consecutive 8-bit writes into 32-bit little-endian words and buffers them in a small show-ahead FIFO.
- Presents words on a valid/ready interface to the next stage, such as a bus master or DMA.
- Supports an explicit flush of partial words and flags lost data.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries in the output FIFO; power of 2, minimum 2.

Ports:
- i_clk  input  1  system clock; all logic rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- iv_data  input  8  byte from cdc stage.
- i_data_wr  input  1  byte strobe; `iv_data` is sampled on every edge where it is high.
- i_flush  input  1  single-cycle request to emit the current partial word.
- i_word_ready  input  1  downstream accepts the head word.
- ov_word  output  32  head word; byte 0 is in [7:0].
- ov_word_bytes  output  3  valid byte count of the head word, 1..4.
- o_word_valid  output  1  head word valid (FIFO not empty).
- o_overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- ov_err_cnt  output  16  sequence error count; see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - `ov_word`=0, `ov_word_bytes`=0, `o_word_valid`=0, `o_overflow`=0, `ov_err_cnt`=0.
  - Byte counter=0, partial word cleared, FIFO emptied.
- Reset mid-word or with the FIFO occupied discards all held data.
- Assembly:
  - 2-bit byte counter `cnt` (0..3) plus a 24-bit holding register for bytes 0..2.
  - On a write edge with `cnt`<3: store the byte in lane `cnt`, then `cnt`+1.
  - On a write edge with `cnt`=3: push {`iv_data`, lane2, lane1, lane0} with bytes=4 into the FIFO on the same edge; `cnt`=0.
  - Latency: `o_word_valid` is high in the cycle immediately after the 4th byte is sampled, provided the FIFO was empty.
- Flush, evaluated on the same edge after any write:
  - Effective count = `cnt` + (`i_data_wr` ? 1 : 0).
  - Effective count 1..3: push the partial word with unused upper lanes=0 and `ov_word_bytes`=effective count; `cnt`=0.
  - Effective count 4: the normal full word is pushed; the flush adds nothing.
  - Effective count 0: no-op.
- At most one push per edge.
- Output handshake:
  - Pop occurs on an edge where `o_word_valid` && `i_word_ready`.
  - `ov_word`/`ov_word_bytes` hold stable while `o_word_valid`=1 and `i_word_ready`=0.
  - When the FIFO is empty, `ov_word`/`ov_word_bytes` hold their last value; the consumer must ignore them.
- FIFO:
  - Circular read/write pointers with an extra wrap bit; full when the pointers differ only in the wrap bit.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when full: pop frees a slot and the push is accepted; no overflow.
- Push when full without a pop:
  - Word is dropped and `o_overflow` is set until reset.
  - Assembly state still clears (`cnt`=0); no stall is applied upstream, because the cdc stage has no backpressure.
- Push and pop when empty: the word is written and `o_word_valid` rises next cycle. There is no bypass.

Optional Feature:
- Macro: BYTE_WORD_PACKER_SEQCHK_EN.
- Defined:
  - Each sampled byte is compared with the previous sampled byte + 1 (mod 256).
  - The first byte after reset only loads the reference and never counts as an error.
  - On a mismatch, `ov_err_cnt` increments, saturating at 0xFFFF.
  - The reference always updates to the current byte.
  - Flush does not affect the check.
- Not defined: `ov_err_cnt` is constant 0, no comparator logic is generated, and the port remains present.

Test Plan:
1. Bytes 0x01..0x10 back-to-back, `i_word_ready`=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, each with bytes=4; first `o_word_valid` one cycle after 0x04 is sampled; `o_overflow`=0.
2. Bytes 0x01..0x06, 2 idle cycles, then `i_flush` pulse -> 0x04030201 (4), then 0x00000605 (2); a second flush with `cnt`=0 produces no word.
3. `i_word_ready`=0, bytes 0x01..0x14 (5 words) -> FIFO holds 4 words, 5th dropped, `o_overflow`=1; then `i_word_ready`=1 drains exactly 0x04030201..0x100F0E0D in order and `o_overflow` stays 1.
4. Bytes 0xAA, 0xBB, then 0xCC with `i_flush` in the same cycle -> single word 0x00CCBBAA, bytes=3; next bytes 0x01..0x04 -> 0x04030201.
5. FIFO full with `i_word_ready`=1 and a 4th byte arriving on the same edge -> push accepted, `o_overflow` stays 0. Separately: `i_rst_n` low after 2 bytes -> all outputs 0; then 0x11..0x14 -> 0x14131211.
6. Macro defined: bytes 01, 02, 03, 05, 06 -> `ov_err_cnt`=1. Macro undefined: same stimulus -> `ov_err_cnt`=0 and words identical.
